// File: rtl/hwrandom_port_scheduler.sv
// hwrandom_port_scheduler
// Buffers random bytes in a small FIFO and hands them out round-robin to the
// UART transmitters that are both enabled and idle. Entropy is never stalled:
// bytes arriving on a full FIFO are dropped and counted.
module hwrandom_port_scheduler #(
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    in_byte,
  input  logic                          in_valid,
  input  logic [NUM_PORTS-1:0]          port_enable,
  input  logic [NUM_PORTS-1:0]          tx_ready,
  output logic [NUM_PORTS-1:0]          tx_start,
  output logic [7:0]                    tx_byte,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   drop_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PW:0]   DEPTH     = (PW+1)'(FIFO_DEPTH);
  localparam logic [GW-1:0] LAST_PORT = GW'(NUM_PORTS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [7:0]           mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [1:0]           state;
  logic [GW-1:0]        last_grant;

  logic                 fifo_full;
  logic                 push;
  logic                 drop;
  logic                 pop;
  logic [NUM_PORTS-1:0] elig;
  logic [GW-1:0]        grant_idx;
  logic [GW-1:0]        cand;
  logic                 grant_found;
  logic [NUM_PORTS-1:0] grant_oh;

  assign fifo_full = (fifo_count == DEPTH);
  assign push      = in_valid & ~fifo_full;
  assign drop      = in_valid & fifo_full;
  assign elig      = tx_ready & port_enable;
  assign pop       = (state == S_IDLE) && (fifo_count != '0) && grant_found;

  // Round-robin search starting one past the last granted port.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      cand = GW'((32'(last_grant) + i) % NUM_PORTS);
      if (!grant_found && elig[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // One-hot form of the winning port.
  always_comb begin
    grant_oh            = '0;
    grant_oh[grant_idx] = 1'b1;
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_byte;
  end

  // FIFO pointers, occupancy and saturating drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
      if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
    end
  end

  // Grant FSM: IDLE picks a port and pops, ISSUE pulses, GAP lets tx_ready fall.
  // tx_start is loaded on the IDLE->ISSUE edge so the pulse is registered yet
  // still lines up exactly with the ISSUE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      last_grant <= LAST_PORT;
      tx_start   <= '0;
      tx_byte    <= '0;
    end else begin
      tx_start <= '0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            tx_byte    <= mem[rd_ptr];
            last_grant <= grant_idx;
            tx_start   <= grant_oh;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_GAP;
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hwrandom_port_scheduler.sv
// Directed bench for hwrandom_port_scheduler (4 ports, 8-deep FIFO).
module tb_hwrandom_port_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic [3:0]  port_enable;
  logic [3:0]  tx_ready;
  logic [3:0]  tx_start;
  logic [7:0]  tx_byte;
  logic [3:0]  fifo_count;
  logic [15:0] drop_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [3:0] q_port[$];
  logic [7:0] q_byte[$];
  int         q_cyc[$];
  logic [3:0] seen_or;

  always #5 clk = ~clk;

  hwrandom_port_scheduler #(.NUM_PORTS(4), .FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_byte     (in_byte),
    .in_valid    (in_valid),
    .port_enable (port_enable),
    .tx_ready    (tx_ready),
    .tx_start    (tx_start),
    .tx_byte     (tx_byte),
    .fifo_count  (fifo_count),
    .drop_count  (drop_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive one cycle of input, advance, log any start pulse seen afterwards.
  task automatic cycle(input logic v, input logic [7:0] b);
    in_valid = v;
    in_byte  = b;
    step();
    in_valid = 1'b0;
    if (tx_start != 4'b0000) begin
      q_port.push_back(tx_start);
      q_byte.push_back(tx_byte);
      q_cyc.push_back(cyc);
    end
    seen_or = seen_or | tx_start;
  endtask

  task automatic clear_log();
    q_port.delete();
    q_byte.delete();
    q_cyc.delete();
    seen_or = 4'b0000;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    clear_log();
  endtask

  initial begin
    int start;
    logic [3:0] exp_rr [6];
    logic [3:0] exp_sk [3];
    exp_rr = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
    exp_sk = '{4'h2, 4'h8, 4'h2};

    reset       = 1'b0;
    in_valid    = 1'b0;
    in_byte     = 8'h00;
    port_enable = 4'hF;
    tx_ready    = 4'hF;
    seen_or     = 4'b0000;

    // Basic latency
    do_reset();
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_byte", 32'(tx_byte), 0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_drop_count", 32'(drop_count), 0);
    cycle(1'b1, 8'hA5);
    check("lat_count_n1", 32'(fifo_count), 1);
    check("lat_start_n1", 32'(tx_start), 0);
    cycle(1'b0, 8'h00);
    check("lat_start_n2", 32'(tx_start), 32'h1);
    check("lat_byte_n2", 32'(tx_byte), 32'hA5);
    check("lat_count_n2", 32'(fifo_count), 0);
    cycle(1'b0, 8'h00);
    check("lat_start_n3", 32'(tx_start), 0);
    check("lat_byte_hold", 32'(tx_byte), 32'hA5);
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);

    // Round-robin order
    do_reset();
    start = cyc;
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(i + 1));
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00);
    check("rr_count", 32'(q_port.size()), 6);
    for (int i = 0; i < 6 && i < q_port.size(); i++) begin
      check("rr_port", 32'(q_port[i]), 32'(exp_rr[i]));
      check("rr_byte", 32'(q_byte[i]), 32'(i + 1));
      if (i == 0) check("rr_first_lat", 32'(q_cyc[0] - start), 2);
      else        check("rr_spacing", 32'(q_cyc[i] - q_cyc[i-1]), 3);
    end

    // Skip busy/disabled
    do_reset();
    port_enable = 4'b1011;
    tx_ready    = 4'b1110;
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h31 + i));
    for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00);
    check("skip_count", 32'(q_port.size()), 3);
    for (int i = 0; i < 3 && i < q_port.size(); i++) begin
      check("skip_port", 32'(q_port[i]), 32'(exp_sk[i]));
      check("skip_byte", 32'(q_byte[i]), 32'(8'h31 + i));
    end
    check("skip_port2_never", 32'(seen_or[2]), 0);

    // No eligible port, then one becomes ready
    do_reset();
    port_enable = 4'hF;
    tx_ready    = 4'b0000;
    for (int i = 0; i < 12; i++) cycle(1'b1, 8'(8'h10 + i));
    check("noel_fifo_count", 32'(fifo_count), 8);
    check("noel_drop_count", 32'(drop_count), 4);
    check("noel_no_start", 32'(q_port.size()), 0);
    tx_ready = 4'b0100;
    cycle(1'b0, 8'h00);
    check("noel_start_p2", 32'(tx_start), 32'h4);
    check("noel_byte", 32'(tx_byte), 32'h10);
    check("noel_count_after", 32'(fifo_count), 7);

    // Full FIFO, push in the same cycle as a pop
    do_reset();
    tx_ready = 4'b0000;
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h50 + i));
    check("full_count", 32'(fifo_count), 8);
    check("full_drop0", 32'(drop_count), 0);
    tx_ready = 4'hF;
    cycle(1'b1, 8'hEE);
    check("fullpop_drop", 32'(drop_count), 1);
    check("fullpop_count", 32'(fifo_count), 7);
    check("fullpop_start", 32'(tx_start), 32'h1);
    check("fullpop_byte", 32'(tx_byte), 32'h50);

    // Reset mid-pulse
    do_reset();
    tx_ready = 4'b0000;
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h60 + i));
    tx_ready = 4'b0010;
    cycle(1'b0, 8'h00);
    tx_ready = 4'b0000;
    check("mid_start_p1", 32'(tx_start), 32'h2);
    check("mid_drop", 32'(drop_count), 2);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_start", 32'(tx_start), 0);
    check("mid_rst_count", 32'(fifo_count), 0);
    check("mid_rst_drop", 32'(drop_count), 0);
    check("mid_rst_byte", 32'(tx_byte), 0);
    step();
    reset = 1'b1;
    step();
    clear_log();
    tx_ready = 4'hF;
    cycle(1'b1, 8'h77);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00);
    check("post_rst_pulses", 32'(q_port.size()), 1);
    if (q_port.size() > 0) begin
      check("post_rst_port", 32'(q_port[0]), 32'h1);
      check("post_rst_byte", 32'(q_byte[0]), 32'h77);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
